exec_sequencer: RTL and testbench

- Multi-cycle control FSM for the RV32E core datapath (PC register, register file, instruction register, load/store unit).
- Replaces the implicit always-enabled PC and regfile writes with explicit enables.
- Sequences fetch, decode, memory access and write-back over valid/ready memory handshakes.
- Raises halt on ebreak and fault on illegal instructions or memory timeouts.

---
 rtl/exec_sequencer_pkg.sv | 20 ++
 rtl/exec_sequencer_watchdog.sv | 32 +++
 rtl/exec_sequencer.sv | 125 ++++++++++++
 tb/tb_exec_sequencer.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/exec_sequencer_pkg.sv
// Shared types for the RV32E multi-cycle sequencer: state encoding and fault codes.
package exec_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_FETCH_REQ  = 3'd1,
    ST_FETCH_WAIT = 3'd2,
    ST_DECODE     = 3'd3,
    ST_MEM_REQ    = 3'd4,
    ST_MEM_WAIT   = 3'd5,
    ST_WB         = 3'd6,
    ST_STOP       = 3'd7
  } seq_state_t;

  localparam logic [1:0] FAULT_NONE    = 2'd0;
  localparam logic [1:0] FAULT_ILLEGAL = 2'd1;
  localparam logic [1:0] FAULT_IF_TO   = 2'd2;
  localparam logic [1:0] FAULT_LS_TO   = 2'd3;

endpackage

// File: rtl/exec_sequencer_watchdog.sv
// Wait-cycle watchdog for the sequencer handshake states; only built when
// SEQ_WATCHDOG_EN is defined.
`ifdef SEQ_WATCHDOG_EN
module seq_watchdog #(
  parameter int TIMEOUT_W = 8,
  parameter int MAX_WAIT  = 200
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic expired
);

  logic [TIMEOUT_W-1:0] cnt;

  // cnt holds the cycles already spent in the current state, so the
  // MAX_WAIT-th waiting cycle is the one that sees MAX_WAIT-1.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + TIMEOUT_W'(1);
    end
  end

  assign expired = en && !clr && (cnt == TIMEOUT_W'(MAX_WAIT - 1));

endmodule
`endif

// File: rtl/exec_sequencer.sv
// Multi-cycle fetch/decode/memory/write-back sequencer for the RV32E datapath.
// Optional handshake watchdog enabled by defining SEQ_WATCHDOG_EN.
module exec_sequencer
  import exec_sequencer_pkg::*;
#(
  parameter int TIMEOUT_W = 8,
  parameter int MAX_WAIT  = 200
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic        if_req_valid,
  input  logic        if_req_ready,
  input  logic        if_rsp_valid,
  output logic        if_rsp_ready,
  output logic        ir_wen,
  input  logic        dec_mem_rd,
  input  logic        dec_mem_wr,
  input  logic        dec_reg_write,
  input  logic        dec_ebreak,
  input  logic        dec_illegal,
  output logic        ls_req_valid,
  input  logic        ls_req_ready,
  input  logic        ls_rsp_valid,
  output logic        pc_wen,
  output logic        rf_wen,
  output logic        halt,
  output logic        fault,
  output logic [1:0]  fault_code,
  output logic [31:0] instr_cnt,
  output logic [2:0]  state_dbg
);

  // Handshakes: a request is transferred on the rising edge where valid and
  // ready are both 1; valid is never withdrawn before that edge.

  if (MAX_WAIT < 1 || MAX_WAIT >= (1 << TIMEOUT_W)) begin : g_bad_cfg
    $error("exec_sequencer: MAX_WAIT must be in 1 .. 2**TIMEOUT_W-1");
  end

  seq_state_t state;
  logic       wb_rf;

`ifdef SEQ_WATCHDOG_EN
  logic in_hs;
  logic advance;
  logic wd_expired;

  assign in_hs = (state == ST_FETCH_REQ) || (state == ST_FETCH_WAIT) ||
                 (state == ST_MEM_REQ)   || (state == ST_MEM_WAIT);
  assign advance = ((state == ST_FETCH_REQ)  && if_req_ready) ||
                   ((state == ST_FETCH_WAIT) && if_rsp_valid) ||
                   ((state == ST_MEM_REQ)    && ls_req_ready) ||
                   ((state == ST_MEM_WAIT)   && ls_rsp_valid);

  seq_watchdog #(
    .TIMEOUT_W (TIMEOUT_W),
    .MAX_WAIT  (MAX_WAIT)
  ) u_watchdog (
    .clk     (clk),
    .rst     (rst),
    .en      (in_hs),
    .clr     (!in_hs || advance),
    .expired (wd_expired)
  );
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= ST_IDLE;
      wb_rf      <= 1'b0;
      halt       <= 1'b0;
      fault      <= 1'b0;
      fault_code <= FAULT_NONE;
      instr_cnt  <= '0;
    end else begin
      case (state)
        ST_IDLE:       if (start) state <= ST_FETCH_REQ;
        ST_FETCH_REQ:  if (if_req_ready) state <= ST_FETCH_WAIT;
        ST_FETCH_WAIT: if (if_rsp_valid) state <= ST_DECODE;
        ST_DECODE: begin
          // Register-write intent is captured here so WB decodes from state only.
          wb_rf <= dec_reg_write && !dec_mem_wr;
          if (dec_illegal) begin
            state      <= ST_STOP;
            fault      <= 1'b1;
            fault_code <= FAULT_ILLEGAL;
          end else if (dec_ebreak) begin
            state     <= ST_STOP;
            halt      <= 1'b1;
            instr_cnt <= instr_cnt + 32'd1;
          end else if (dec_mem_rd || dec_mem_wr) begin
            state <= ST_MEM_REQ;
          end else begin
            state <= ST_WB;
          end
        end
        ST_MEM_REQ:  if (ls_req_ready) state <= ST_MEM_WAIT;
        ST_MEM_WAIT: if (ls_rsp_valid) state <= ST_WB;
        ST_WB: begin
          instr_cnt <= instr_cnt + 32'd1;
          state     <= ST_FETCH_REQ;
        end
        default: state <= ST_STOP;
      endcase
`ifdef SEQ_WATCHDOG_EN
      if (wd_expired) begin
        state      <= ST_STOP;
        fault      <= 1'b1;
        fault_code <= ((state == ST_FETCH_REQ) || (state == ST_FETCH_WAIT)) ?
                      FAULT_IF_TO : FAULT_LS_TO;
      end
`endif
    end
  end

  assign if_req_valid = (state == ST_FETCH_REQ);
  assign if_rsp_ready = (state == ST_FETCH_WAIT);
  assign ir_wen       = (state == ST_FETCH_WAIT) && if_rsp_valid;
  assign ls_req_valid = (state == ST_MEM_REQ);
  assign pc_wen       = (state == ST_WB);
  assign rf_wen       = (state == ST_WB) && wb_rf;
  assign state_dbg    = state;

endmodule

// File: tb/tb_exec_sequencer.sv
// Directed/random bench for exec_sequencer: per-cycle expected output vectors
// are queued from the instruction timeline and compared each cycle.
module tb_exec_sequencer;

`ifdef SEQ_WATCHDOG_EN
  localparam int MAXW = 5;
`else
  localparam int MAXW = 200;
`endif
  localparam int W = 45;

  localparam logic [5:0] C_IFV = 6'b100000;
  localparam logic [5:0] C_RR  = 6'b010000;
  localparam logic [5:0] C_IRW = 6'b001000;
  localparam logic [5:0] C_LSV = 6'b000100;
  localparam logic [5:0] C_PC  = 6'b000010;
  localparam logic [5:0] C_RF  = 6'b000001;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        if_req_valid, if_req_ready, if_rsp_valid, if_rsp_ready, ir_wen;
  logic        dec_mem_rd, dec_mem_wr, dec_reg_write, dec_ebreak, dec_illegal;
  logic        ls_req_valid, ls_req_ready, ls_rsp_valid;
  logic        pc_wen, rf_wen, halt, fault;
  logic [1:0]  fault_code;
  logic [31:0] instr_cnt;
  logic [2:0]  state_dbg;

  int          total = 0;
  int          bad = 0;
  logic [31:0] exp_cnt;
  logic [W-1:0] exp_q[$];

  // clock / reset block
  always #5 clk = ~clk;

  exec_sequencer #(
    .TIMEOUT_W (8),
    .MAX_WAIT  (MAXW)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .if_req_valid  (if_req_valid),
    .if_req_ready  (if_req_ready),
    .if_rsp_valid  (if_rsp_valid),
    .if_rsp_ready  (if_rsp_ready),
    .ir_wen        (ir_wen),
    .dec_mem_rd    (dec_mem_rd),
    .dec_mem_wr    (dec_mem_wr),
    .dec_reg_write (dec_reg_write),
    .dec_ebreak    (dec_ebreak),
    .dec_illegal   (dec_illegal),
    .ls_req_valid  (ls_req_valid),
    .ls_req_ready  (ls_req_ready),
    .ls_rsp_valid  (ls_rsp_valid),
    .pc_wen        (pc_wen),
    .rf_wen        (rf_wen),
    .halt          (halt),
    .fault         (fault),
    .fault_code    (fault_code),
    .instr_cnt     (instr_cnt),
    .state_dbg     (state_dbg)
  );

  function automatic logic [W-1:0] pack(input logic [2:0] st, input logic [5:0] ctl,
                                        input logic h, input logic fl,
                                        input logic [1:0] fc, input logic [31:0] cnt);
    return {st, ctl, h, fl, fc, cnt};
  endfunction

  function automatic logic [W-1:0] obs();
    return pack(state_dbg, {if_req_valid, if_rsp_ready, ir_wen, ls_req_valid, pc_wen, rf_wen},
                halt, fault, fault_code, instr_cnt);
  endfunction

  task automatic chk(input string tag, input logic [W-1:0] o, input logic [W-1:0] e);
    total++;
    assert (o === e) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, o, e);
    end
  endtask

  // driver tasks
  task automatic do_reset_start();
    rst = 1'b1;
    start = 1'b0;
    if_req_ready = 1'b0; if_rsp_valid = 1'b0;
    ls_req_ready = 1'b0; ls_rsp_valid = 1'b0;
    dec_mem_rd = 1'b0; dec_mem_wr = 1'b0; dec_reg_write = 1'b0;
    dec_ebreak = 1'b0; dec_illegal = 1'b0;
    exp_cnt = 32'd0;
    #1 rst = 1'b0;
    #1 chk("reset", obs(), '0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    #1 chk("idle", obs(), '0);
    start = 1'b1;
  endtask

  // Runs one instruction from its first FETCH_REQ cycle. f = fetch-ready delay,
  // ld = load/store response delay, to_kind 1/2 = fetch/memory timeout,
  // extra = cycles observed in STOP, abort_at = stop driving after that cycle.
  task automatic run_instr(input string name, input logic rd, input logic wr,
                           input logic regw, input logic ebrk, input logic ill,
                           input int f, input int ld, input int to_kind,
                           input int extra, input logic poke, input int abort_at);
    logic       mem;
    int         n;
    logic [2:0] st;
    logic [5:0] ctl;
    logic       h, fl;
    logic [1:0] fc;
    logic [31:0] cnt;
    mem = rd | wr;
    if (abort_at > 0)          n = abort_at;
    else if (to_kind == 1)     n = f + 1 + MAXW + extra;
    else if (to_kind == 2)     n = f + 4 + MAXW + extra;
    else if (ill || ebrk)      n = f + 3 + extra;
    else if (mem)              n = f + 6 + ld;
    else                       n = f + 4;

    for (int c = 1; c <= n; c++) begin
      st = 3'd0; ctl = 6'd0; h = 1'b0; fl = 1'b0; fc = 2'd0; cnt = exp_cnt;
      if (c <= f + 1) begin
        st = 3'd1; ctl = C_IFV;
      end else if (to_kind == 1) begin
        if (c <= f + 1 + MAXW) begin st = 3'd2; ctl = C_RR; end
        else begin st = 3'd7; fl = 1'b1; fc = 2'd2; end
      end else if (c == f + 2) begin
        st = 3'd2; ctl = C_RR | C_IRW;
      end else if (c == f + 3) begin
        st = 3'd3;
      end else if (ill) begin
        st = 3'd7; fl = 1'b1; fc = 2'd1;
      end else if (ebrk) begin
        st = 3'd7; h = 1'b1; cnt = exp_cnt + 32'd1;
      end else if (mem) begin
        if (c == f + 4) begin st = 3'd4; ctl = C_LSV; end
        else if (to_kind == 2) begin
          if (c <= f + 4 + MAXW) st = 3'd5;
          else begin st = 3'd7; fl = 1'b1; fc = 2'd3; end
        end else if (c <= f + 5 + ld) st = 3'd5;
        else begin st = 3'd6; ctl = C_PC | ((regw && !wr) ? C_RF : 6'd0); end
      end else begin
        st = 3'd6; ctl = C_PC | (regw ? C_RF : 6'd0);
      end
      exp_q.push_back(pack(st, ctl, h, fl, fc, cnt));
    end

    dec_mem_rd = rd; dec_mem_wr = wr; dec_reg_write = regw;
    dec_ebreak = ebrk; dec_illegal = ill;
    for (int c = 1; c <= n; c++) begin
      @(negedge clk);
      start        = poke && (c > f + 3) && (c % 2 == 0);
      if_req_ready = (c == f + 1);
      if_rsp_valid = (to_kind != 1) && (c == f + 2);
      ls_req_ready = (c == f + 4);
      ls_rsp_valid = (to_kind != 2) && (c == f + 5 + ld);
      #1 chk($sformatf("%s cyc%0d", name, c), obs(), exp_q.pop_front());
    end
    if (abort_at == 0 && !ill && to_kind == 0) exp_cnt = exp_cnt + 32'd1;
  endtask

  initial begin
    int kind;
    if_req_ready = 1'b0; if_rsp_valid = 1'b0;
    ls_req_ready = 1'b0; ls_rsp_valid = 1'b0;
    dec_mem_rd = 1'b0; dec_mem_wr = 1'b0; dec_reg_write = 1'b0;
    dec_ebreak = 1'b0; dec_illegal = 1'b0;
    @(negedge clk);

    // back-to-back instruction stream
    do_reset_start();
    run_instr("addi",     0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    run_instr("load_dly", 1, 0, 1, 0, 0, 3, 2, 0, 0, 0, 0);
    run_instr("store",    0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    run_instr("branch",   0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
    run_instr("load_z",   1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 8; i++) begin
      kind = $urandom_range(0, 2);
      run_instr($sformatf("rnd%0d", i), kind == 1, kind == 2, 1'($urandom_range(0, 1)),
                0, 0, $urandom_range(0, 3), $urandom_range(0, 3), 0, 0, 0, 0);
    end

    // ebreak after three addi, start pulses in STOP ignored
    do_reset_start();
    for (int i = 0; i < 3; i++) run_instr("addi_pre", 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    run_instr("ebreak", 0, 0, 0, 1, 0, 0, 0, 0, 4, 1, 0);

    // illegal wins over ebreak
    do_reset_start();
    run_instr("addi_one", 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    run_instr("ill_ebrk", 0, 0, 1, 1, 1, 0, 0, 0, 3, 1, 0);

    do_reset_start();
    run_instr("illegal", 1, 0, 1, 0, 1, 2, 0, 0, 2, 0, 0);

    // reset asserted in the middle of MEM_WAIT
    do_reset_start();
    run_instr("load_abort", 1, 0, 1, 0, 0, 0, 10, 0, 0, 0, 7);
    rst = 1'b0;
    #1 chk("rst_mid", obs(), '0);
    @(negedge clk);
    #1 chk("rst_hold", obs(), '0);

`ifdef SEQ_WATCHDOG_EN
    do_reset_start();
    run_instr("if_timeout", 0, 0, 1, 0, 0, 1, 0, 1, 2, 1, 0);
    do_reset_start();
    run_instr("ls_timeout", 1, 0, 1, 0, 0, 0, 0, 2, 2, 0, 0);
`endif

    // final report
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
